// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative
// radix-2 Booth multiply and non-restoring divide behind a start/busy/done handshake.
module seq_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [3:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 flag_z,
  output logic                 flag_n,
  output logic                 flag_c,
  output logic                 flag_v,
  output logic                 flag_dbz,
  output logic                 flag_ill
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_SHR = 4'b0100;
  localparam logic [3:0] OP_SHL = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [3:0] OP_ROL = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_DIV = 4'b1001;
  localparam logic [3:0] OP_NEG = 4'b1010;
  localparam logic [3:0] OP_NOT = 4'b1011;

  typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_FIX} state_t;

  state_t           state;
  logic [SHW-1:0]   cnt;
  logic             is_div_q;
  logic             dbz_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic [WIDTH:0]   acc_q;
  logic [WIDTH-1:0] q_q;
  logic             qm1_q;
  logic [WIDTH:0]   m_q;

  // Single-cycle result and flag logic
  logic [WIDTH:0]     sum_w;
  logic [WIDTH:0]     diff_w;
  logic [WIDTH-1:0]   neg_b;
  logic [2*WIDTH-1:0] dbl_a;
  logic [SHW-1:0]     amt;
  logic [SHW-1:0]     rol_amt;
  logic [WIDTH-1:0]   sc_lo;
  logic               sc_c;
  logic               sc_v;
  logic               sc_ill;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  always_comb begin
    amt     = b[SHW-1:0];
    rol_amt = ~amt + SHW'(1);
    sum_w   = {1'b0, a} + {1'b0, b};
    diff_w  = {1'b0, a} - {1'b0, b};
    neg_b   = ~b + WIDTH'(1);
    dbl_a   = {a, a};
    a_mag   = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    b_mag   = b[WIDTH-1] ? neg_b : b;
    sc_lo   = '0;
    sc_c    = 1'b0;
    sc_v    = 1'b0;
    sc_ill  = 1'b0;
    case (op)
      OP_AND: sc_lo = a & b;
      OP_OR:  sc_lo = a | b;
      OP_ADD: begin
        sc_lo = sum_w[WIDTH-1:0];
        sc_c  = sum_w[WIDTH];
        sc_v  = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_lo = diff_w[WIDTH-1:0];
        sc_c  = ~diff_w[WIDTH];
        sc_v  = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SHR: sc_lo = a >> amt;
      OP_SHL: sc_lo = a << amt;
      OP_ROR: sc_lo = WIDTH'(dbl_a >> amt);
      OP_ROL: sc_lo = WIDTH'(dbl_a >> rol_amt);
      OP_NEG: begin
        sc_lo = neg_b;
        sc_v  = b[WIDTH-1] && neg_b[WIDTH-1];
      end
      OP_NOT: sc_lo = ~b;
      OP_MUL, OP_DIV: sc_lo = '0;
      default: sc_ill = 1'b1;
    endcase
  end

  // Iterative step datapath: Booth add/sub, non-restoring step, and final fix-up
  logic [WIDTH:0]   booth_t;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_t;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

  always_comb begin
    booth_t = acc_q;
    case ({q_q[0], qm1_q})
      2'b01:   booth_t = acc_q + m_q;
      2'b10:   booth_t = acc_q - m_q;
      default: booth_t = acc_q;
    endcase
    div_sh  = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    div_t   = acc_q[WIDTH] ? (div_sh + m_q) : (div_sh - m_q);
    rem_fix = acc_q[WIDTH] ? (acc_q[WIDTH-1:0] + m_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    quo     = neg_quo_q ? (~q_q + WIDTH'(1)) : q_q;
    rem     = neg_rem_q ? (~rem_fix + WIDTH'(1)) : rem_fix;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      is_div_q  <= 1'b0;
      dbz_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      acc_q     <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      m_q       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
      flag_dbz  <= 1'b0;
      flag_ill  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (op == OP_MUL || op == OP_DIV) begin
              busy      <= 1'b1;
              result    <= '0;
              flag_z    <= 1'b0;
              flag_n    <= 1'b0;
              flag_c    <= 1'b0;
              flag_v    <= 1'b0;
              flag_dbz  <= 1'b0;
              flag_ill  <= 1'b0;
              cnt       <= '0;
              acc_q     <= '0;
              qm1_q     <= 1'b0;
              is_div_q  <= (op == OP_DIV);
              neg_quo_q <= a[WIDTH-1] ^ b[WIDTH-1];
              neg_rem_q <= a[WIDTH-1];
              if (op == OP_MUL) begin
                q_q   <= b;
                m_q   <= {a[WIDTH-1], a};
                dbz_q <= 1'b0;
                state <= ST_ITER;
              end else begin
                // Divide by zero keeps raw a in q_q so FIX can return it in HI
                q_q   <= (b == '0) ? a : a_mag;
                m_q   <= {1'b0, b_mag};
                dbz_q <= (b == '0);
                state <= (b == '0) ? ST_FIX : ST_ITER;
              end
            end else begin
              result   <= {{WIDTH{1'b0}}, sc_lo};
              flag_z   <= (sc_lo == '0);
              flag_n   <= sc_lo[WIDTH-1];
              flag_c   <= sc_c;
              flag_v   <= sc_v;
              flag_dbz <= 1'b0;
              flag_ill <= sc_ill;
              done     <= 1'b1;
            end
          end
        end
        ST_ITER: begin
          if (is_div_q) begin
            acc_q <= div_t;
            q_q   <= {q_q[WIDTH-2:0], ~div_t[WIDTH]};
          end else begin
            acc_q <= {booth_t[WIDTH], booth_t[WIDTH:1]};
            q_q   <= {booth_t[0], q_q[WIDTH-1:1]};
            qm1_q <= q_q[0];
          end
          cnt <= cnt + SHW'(1);
          if (cnt == SHW'(WIDTH - 1)) state <= ST_FIX;
        end
        ST_FIX: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_IDLE;
          if (!is_div_q) begin
            result <= {acc_q[WIDTH-1:0], q_q};
            flag_z <= ({acc_q[WIDTH-1:0], q_q} == '0);
            flag_n <= acc_q[WIDTH-1];
          end else if (dbz_q) begin
            result   <= {q_q, {WIDTH{1'b1}}};
            flag_z   <= 1'b0;
            flag_n   <= 1'b1;
            flag_dbz <= 1'b1;
          end else begin
            result <= {rem, quo};
            flag_z <= ({rem, quo} == '0);
            flag_n <= quo[WIDTH-1];
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
